imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous memory (BIOS/IMEM-style, 4096 x 32) between two requesters: instruction fetch (port F) and data load/store (port D).
- Issues at most one memory access per cycle and returns read data to the correct requester after the memory's fixed read latency.
- Data side has priority by default; a starvation counter guarantees fetch progress.
- Sits between the CPU pipeline stages and the memory macro, replacing the direct IF-to-memory wiring.

---
 rtl/imem_dmem_arbiter_pkg.sv | 14 +
 rtl/imem_dmem_arbiter_tag_pipe.sv | 35 +++
 rtl/imem_dmem_arbiter.sv | 106 ++++++++++
 tb/tb_imem_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the IMEM/DMEM arbiter.
// Owner encoding and the response tag bundle.
package imem_dmem_arbiter_pkg;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int   BE_W  = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_tag_t;

endpackage

// File: rtl/imem_dmem_arbiter_tag_pipe.sv
// Response tag shift register.
// Tracks which requester owns each in-flight read.
module rsp_tag_pipe
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  rsp_tag_t stage [DEPTH];

  // Shift tags toward the output; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= '{valid: in_valid, owner: in_owner};
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_valid = stage[DEPTH-1].valid;
  assign out_owner = stage[DEPTH-1].owner;

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Fetch/data arbiter for one single-port memory.
// Data wins by default; a starvation counter forces fetch.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STARVE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BE_W-1:0]   d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

  logic [CW-1:0] starve_cnt;
  logic          starve_force;
  logic          tag_in_valid;
  logic          tag_in_owner;
  logic          tag_out_valid;
  logic          tag_out_owner;

  assign starve_force = (starve_cnt == CNT_MAX);

  // Winner select; grants are held off while reset is asserted.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    priority case (1'b1)
      !rst:                  ;
      starve_force && f_req: f_gnt = 1'b1;
      d_req:                 d_gnt = 1'b1;
      f_req:                 f_gnt = 1'b1;
      default:               ;
    endcase
  end

  // Memory port mux follows the winner; idle drives zeros.
  always_comb begin
    mem_addr = '0;
    mem_we   = '0;
    mem_din  = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      mem_we   = d_we;
      mem_din  = d_wdata;
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  assign mem_en = f_gnt | d_gnt;

  // Count consecutive denied fetch cycles, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (f_req && !f_gnt) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Only reads produce a response.
  assign tag_in_valid = f_gnt | (d_gnt && (d_we == '0));
  assign tag_in_owner = d_gnt ? OWN_D : OWN_F;

  rsp_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tag_in_valid),
    .in_owner (tag_in_owner),
    .out_valid(tag_out_valid),
    .out_owner(tag_out_owner)
  );

  assign f_rvalid = tag_out_valid && (tag_out_owner == OWN_F);
  assign d_rvalid = tag_out_valid && (tag_out_owner == OWN_D);
  assign f_rdata  = f_rvalid ? mem_dout : '0;
  assign d_rdata  = d_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter at read latencies 1, 2 and 3.
// All three instances share stimulus; each has its own memory.
module tb_imem_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        f_req;
  logic [11:0] f_addr;
  logic        d_req;
  logic [11:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;

  logic        fg    [3];
  logic        dg    [3];
  logic        frv   [3];
  logic        drv   [3];
  logic [31:0] frd   [3];
  logic [31:0] drd   [3];
  logic        men   [3];
  logic [11:0] maddr [3];
  logic [3:0]  mwe   [3];
  logic [31:0] mdin  [3];
  logic [31:0] mdout [3];

  imem_dmem_arbiter #(.RD_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(fg[0]),
    .f_rvalid(frv[0]), .f_rdata(frd[0]),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_gnt(dg[0]),
    .d_rvalid(drv[0]), .d_rdata(drd[0]),
    .mem_en(men[0]), .mem_addr(maddr[0]), .mem_we(mwe[0]),
    .mem_din(mdin[0]), .mem_dout(mdout[0])
  );

  imem_dmem_arbiter #(.RD_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(fg[1]),
    .f_rvalid(frv[1]), .f_rdata(frd[1]),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_gnt(dg[1]),
    .d_rvalid(drv[1]), .d_rdata(drd[1]),
    .mem_en(men[1]), .mem_addr(maddr[1]), .mem_we(mwe[1]),
    .mem_din(mdin[1]), .mem_dout(mdout[1])
  );

  imem_dmem_arbiter #(.RD_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(fg[2]),
    .f_rvalid(frv[2]), .f_rdata(frd[2]),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_gnt(dg[2]),
    .d_rvalid(drv[2]), .d_rdata(drd[2]),
    .mem_en(men[2]), .mem_addr(maddr[2]), .mem_we(mwe[2]),
    .mem_din(mdin[2]), .mem_dout(mdout[2])
  );

  // Memory models: write-first, byte enables, latency 1/2/3.
  logic [31:0] mem [3][4096];
  logic [31:0] dl  [3][3];
  logic        loaded = 1'b0;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] din,
    input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      loaded <= 1'b1;
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < 4096; a++)
          mem[k][a] <= 32'hA500_0000 | a;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (men[k]) begin
          mem[k][maddr[k]] <=
            merge(mem[k][maddr[k]], mdin[k], mwe[k]);
          dl[k][0] <= merge(mem[k][maddr[k]], mdin[k], mwe[k]);
        end else begin
          dl[k][0] <= 32'h0;
        end
        dl[k][1] <= dl[k][0];
        dl[k][2] <= dl[k][1];
      end
    end
  end

  assign mdout[0] = dl[0][0];
  assign mdout[1] = dl[1][1];
  assign mdout[2] = dl[2][2];

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        fr;
    logic [11:0] fa;
    logic        dr;
    logic [11:0] da;
    logic [3:0]  dwe;
    logic [31:0] dwd;
    logic        fg;
    logic        dg;
    logic [11:0] ma;
    logic [3:0]  mwe;
    logic [31:0] mdin;
    logic        frv;
    logic [31:0] frd;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  function automatic vec_t mk(
    input logic fr, input logic [11:0] fa,
    input logic dr, input logic [11:0] da,
    input logic [3:0] dwe, input logic [31:0] dwd,
    input logic efg, input logic edg, input logic [11:0] ema,
    input logic [3:0] emwe, input logic [31:0] emdin,
    input logic efrv, input logic [31:0] efrd,
    input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.dr = dr; v.da = da;
    v.dwe = dwe; v.dwd = dwd;
    v.fg = efg; v.dg = edg; v.ma = ema;
    v.mwe = emwe; v.mdin = emdin;
    v.frv = efrv; v.frd = efrd;
    v.drv = edrv; v.drd = edrd;
    return v;
  endfunction

  task automatic drive(input logic fr, input logic [11:0] fa,
                       input logic dr, input logic [11:0] da,
                       input logic [3:0] we, input logic [31:0] wd);
    f_req = fr; f_addr = fa;
    d_req = dr; d_addr = da; d_we = we; d_wdata = wd;
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, " f_gnt"},    fg[k],    0);
    chk({tag, " d_gnt"},    dg[k],    0);
    chk({tag, " mem_en"},   men[k],   0);
    chk({tag, " mem_we"},   mwe[k],   0);
    chk({tag, " mem_addr"}, maddr[k], 0);
    chk({tag, " mem_din"},  mdin[k],  0);
    chk({tag, " f_rvalid"}, frv[k],   0);
    chk({tag, " d_rvalid"}, drv[k],   0);
    chk({tag, " f_rdata"},  frd[k],   0);
    chk({tag, " d_rdata"},  drd[k],   0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [21];

  initial begin
    // Starvation rows: D every cycle, F every cycle.
    logic sg [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    string s;

    tbl[0]  = mk(1,'h010,0,0,0,0,           1,0,'h010,0,0,
                 0,0,0,0);
    tbl[1]  = mk(1,'h011,0,0,0,0,           1,0,'h011,0,0,
                 1,32'hA500_0010,0,0);
    tbl[2]  = mk(1,'h012,0,0,0,0,           1,0,'h012,0,0,
                 1,32'hA500_0011,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,               0,0,0,0,0,
                 1,32'hA500_0012,0,0);
    tbl[4]  = mk(1,'h010,1,'h100,0,0,       0,1,'h100,0,0,
                 0,0,0,0);
    tbl[5]  = mk(1,'h010,0,0,0,0,           1,0,'h010,0,0,
                 0,0,1,32'hA500_0100);
    tbl[6]  = mk(0,0,0,0,0,0,               0,0,0,0,0,
                 1,32'hA500_0010,0,0);
    tbl[7]  = mk(0,0,1,'h020,4'b0011,32'hDEAD_BEEF,
                 0,1,'h020,4'b0011,32'hDEAD_BEEF,
                 0,0,0,0);
    tbl[8]  = mk(0,0,1,'h020,0,0,           0,1,'h020,0,0,
                 0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,               0,0,0,0,0,
                 0,0,1,32'hA500_BEEF);
    tbl[10] = mk(0,0,0,0,0,0,               0,0,0,0,0,
                 0,0,0,0);
    for (int i = 0; i < 8; i++) begin
      logic pf;
      logic pv;
      pf = (i > 0) && sg[i-1];
      pv = (i > 0) && !sg[i-1];
      tbl[11+i] = mk(1,'h030,1,'h040,0,0,
                     sg[i], !sg[i], sg[i] ? 12'h030 : 12'h040, 0, 0,
                     pf, pf ? 32'hA500_0030 : 32'h0,
                     pv, pv ? 32'hA500_0040 : 32'h0);
    end
    tbl[19] = mk(0,0,0,0,0,0,               0,0,0,0,0,
                 1,32'hA500_0030,0,0);
    tbl[20] = mk(0,0,0,0,0,0,               0,0,0,0,0,
                 0,0,0,0);

    // Reset: both requesters active, everything must stay quiet.
    drive(1, 'h010, 1, 'h020, 4'hF, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #4;
    chk_zero(0, "rst");

    next_cycle();
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].fr, tbl[i].fa, tbl[i].dr, tbl[i].da,
            tbl[i].dwe, tbl[i].dwd);
      #3;
      s = $sformatf("v%0d", i);
      chk({s, " f_gnt"},    fg[0],    tbl[i].fg);
      chk({s, " d_gnt"},    dg[0],    tbl[i].dg);
      chk({s, " mem_en"},   men[0],   tbl[i].fg | tbl[i].dg);
      chk({s, " mem_addr"}, maddr[0], tbl[i].ma);
      chk({s, " mem_we"},   mwe[0],   tbl[i].mwe);
      chk({s, " mem_din"},  mdin[0],  tbl[i].mdin);
      chk({s, " f_rvalid"}, frv[0],   tbl[i].frv);
      chk({s, " f_rdata"},  frd[0],   tbl[i].frd);
      chk({s, " d_rvalid"}, drv[0],   tbl[i].drv);
      chk({s, " d_rdata"},  drd[0],   tbl[i].drd);
      next_cycle();
    end

    // Reset with a read in flight on the latency-2 instance.
    drive(1, 'h050, 0, 0, 0, 0);
    #3;
    chk("rf issue f_gnt", fg[1], 1);
    next_cycle();
    rst = 1'b0;
    drive(1, 'h050, 1, 'h060, 4'h3, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) begin
      #3;
      chk_zero(1, $sformatf("rf%0d", c));
      next_cycle();
    end
    rst = 1'b1;
    drive(1, 'h051, 0, 0, 0, 0);
    #3;
    chk("rf new f_gnt", fg[1], 1);
    chk("rf new addr", maddr[1], 'h051);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("rf wait f_rvalid", frv[1], 0);
    next_cycle();
    #3;
    chk("rf new f_rvalid", frv[1], 1);
    chk("rf new f_rdata", frd[1], 32'hA500_0051);
    chk("rf new d_rvalid", drv[1], 0);
    next_cycle();
    #3;
    chk("rf done f_rvalid", frv[1], 0);
    next_cycle();

    // Alternating F/D reads on the latency-3 instance.
    for (int c = 0; c < 10; c++) begin
      logic        isf;
      logic [31:0] exp_d;
      if (c < 6) begin
        if (c % 2 == 0) drive(1, 12'h060 + 12'(c), 0, 0, 0, 0);
        else            drive(0, 0, 1, 12'h070 + 12'(c), 0, 0);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      #3;
      s = $sformatf("alt%0d", c);
      if (c < 6) begin
        chk({s, " f_gnt"}, fg[2], (c % 2 == 0));
        chk({s, " d_gnt"}, dg[2], (c % 2 == 1));
      end
      if (c >= 3 && c < 9) begin
        isf = ((c - 3) % 2 == 0);
        exp_d = isf ? (32'hA500_0060 + 32'(c - 3))
                    : (32'hA500_0070 + 32'(c - 3));
        chk({s, " f_rvalid"}, frv[2], isf);
        chk({s, " d_rvalid"}, drv[2], !isf);
        chk({s, " rdata"}, isf ? frd[2] : drd[2], exp_d);
      end else begin
        chk({s, " f_rvalid"}, frv[2], 0);
        chk({s, " d_rvalid"}, drv[2], 0);
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
